// File: rtl/ram_mult_ctrl.sv
// Shift-and-add free multiply controller: fetches a pointer, two operands from RAM,
// multiplies by repeated addition and writes the 10-bit product back after the operands.
module ram_mult_ctrl #(
  parameter logic [9:0] PTR_ADDR = 10'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] ram_rdata,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [9:0] ram_wdata,
  output logic       busy,
  output logic       done,
  output logic [9:0] result,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_PTR = 3'd1,
    RD_A   = 3'd2,
    RD_B   = 3'd3,
    MUL    = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] ptr_q, ptr_d;
  logic [9:0] a_q, a_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] acc_q, acc_d;
  logic [9:0] result_q, result_d;
  logic       ovf_q, ovf_d;
  logic [10:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Bit 10 of the widened sum is the carry that makes the overflow flag sticky.
  assign sum = {1'b0, acc_q} + {1'b0, a_q};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    ram_addr  = PTR_ADDR;
    ram_we    = 1'b0;
    ram_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RD_PTR;
          ovf_d   = 1'b0;
        end
      end
      RD_PTR: begin
        ram_addr = PTR_ADDR;
        ptr_d    = ram_rdata;
        state_d  = RD_A;
      end
      RD_A: begin
        ram_addr = ptr_q;
        a_d      = ram_rdata;
        state_d  = RD_B;
      end
      RD_B: begin
        ram_addr = ptr_q + 10'd1;
        cnt_d    = ram_rdata;
        acc_d    = '0;
        state_d  = MUL;
      end
      MUL: begin
        if (cnt_q != 10'd0) begin
          acc_d = sum[9:0];
          cnt_d = cnt_q - 10'd1;
          if (sum[10]) ovf_d = 1'b1;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        ram_addr  = ptr_q + 10'd2;
        ram_we    = 1'b1;
        ram_wdata = acc_q;
        result_d  = acc_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ram_mult_ctrl.sv
// Scoreboard bench for ram_mult_ctrl: stimulus queues expected writes/completions,
// a monitor compares them as the DUT produces them.
module tb_ram_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] ram_rdata;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [9:0] ram_wdata;
  logic       busy;
  logic       done;
  logic [9:0] result;
  logic       overflow;

  ram_mult_ctrl #(.PTR_ADDR(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge; bench loads share the write port.
  logic [9:0] mem [0:1023];
  logic       ld_en = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [9:0] ld_data = '0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int res; int ovf; int cyc; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", int'(ram_addr), e.addr);
          check("wr_data", int'(ram_wdata), e.data);
          check("wr_cycle", cyc, e.cyc);
          check("wr_busy", int'(busy), 1);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          dn_t d;
          d = dq.pop_front();
          check("done_result", int'(result), d.res);
          check("done_overflow", int'(overflow), d.ovf);
          check("done_cycle", cyc, d.cyc);
          check("done_busy", int'(busy), 1);
        end
      end
    end
  end

  task automatic load(input int a, input int d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'(a); ld_data = 10'(d);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle after the start edge; s = cyc then.
  task automatic pulse_start(output int s, input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Write lands s+b+4, done s+b+5 in this bench's cycle count.
  task automatic expect_job(input int s, input int addr, input int b, input int prod, input int ovf);
    wq.push_back('{addr: addr, data: prod, cyc: s + b + 4});
    dq.push_back('{res: prod, ovf: ovf, cyc: s + b + 5});
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && wq.size() == 0 && dq.size() == 0) break;
    end
    check("jobs_drained", wq.size() + dq.size(), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_we"}, int'(ram_we), 0);
    check({tag, "_addr"}, int'(ram_addr), 0);
    check({tag, "_wdata"}, int'(ram_wdata), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int s;
    rst_n = 1'b0;
    start = 1'b0;
    #1 check_reset_outputs("rst");
    load(0, 10); load(10, 5); load(11, 3); load(12, 0);
    @(negedge clk) rst_n = 1'b1;

    // 5 x 3 = 15
    pulse_start(s, 1'b0);
    expect_job(s, 12, 3, 15, 0);
    wait_idle(60);
    check("mem12_5x3", int'(mem[12]), 15);

    // b = 0: one MUL cycle, writes 0
    load(10, 7); load(11, 0);
    pulse_start(s, 1'b0);
    expect_job(s, 12, 0, 0, 0);
    wait_idle(60);

    // a = 0 still iterates b times
    load(10, 0); load(11, 4);
    pulse_start(s, 1'b0);
    expect_job(s, 12, 4, 0, 0);
    wait_idle(60);

    // 100 x 20 = 2000 -> 976 with overflow
    load(10, 100); load(11, 20);
    pulse_start(s, 1'b0);
    expect_job(s, 12, 20, 976, 1);
    wait_idle(80);
    repeat (3) @(negedge clk);
    check("ovf_sticky", int'(overflow), 1);
    check("result_hold", int'(result), 976);

    // Pointer 1023: B from address 0 (reloaded after pointer read), result at address 1
    load(1023, 4); load(0, 1023);
    pulse_start(s, 1'b0);
    check("ovf_cleared_on_start", int'(overflow), 0);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'd0; ld_data = 10'd2;
    @(negedge clk);
    ld_en = 1'b0;
    expect_job(s, 1, 2, 8, 0);
    wait_idle(60);
    check("mem1_wrap", int'(mem[1]), 8);

    // Reset during MUL aborts with no write
    load(0, 10); load(10, 5); load(11, 3); load(12, 99);
    pulse_start(s, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_mem12", int'(mem[12]), 99);
    rst_n = 1'b1;
    pulse_start(s, 1'b0);
    expect_job(s, 12, 3, 15, 0);
    wait_idle(60);
    check("rerun_mem12", int'(mem[12]), 15);

    // start held high: back-to-back jobs; a pulse while busy is ignored
    pulse_start(s, 1'b1);
    expect_job(s, 12, 3, 15, 0);
    expect_job(s + 10, 12, 3, 15, 0);
    while (cyc < s + 12) @(negedge clk);
    start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle(60);
    repeat (15) @(negedge clk);
    check("no_extra_job_busy", int'(busy), 0);
    check("no_extra_job_queue", wq.size() + dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
